// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: entry layout and flush cause encoding.
package reorder_buffer_pkg;

  localparam int unsigned ROB_ENTRIES = 32;
  localparam int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES);
  localparam int unsigned DATA_W      = 32;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispred;
    logic              exc;
    logic [4:0]        dest_reg;
    logic              reg_write;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  typedef enum logic [1:0] {
    FlushNone      = 2'b00,
    FlushMispred   = 2'b01,
    FlushException = 2'b10
  } flush_cause_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy tracking for the reorder buffer; full/empty come from the count only.
module rob_ptr_ctrl #(
  parameter int unsigned Entries = 32,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alloc_i,
  input  logic            commit_i,
  input  logic            flush_i,
  output logic [IdxW-1:0] head_o,
  output logic [IdxW-1:0] tail_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam logic [IdxW:0] FullCount = (IdxW + 1)'(Entries);

  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [IdxW:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth, so pointer wrap is plain overflow.
      if (alloc_i)  tail_d = tail_q + 1'b1;
      if (commit_i) head_d = head_q + 1'b1;
      unique case ({alloc_i, commit_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, completes out of order, retires one entry per
// cycle from head and raises a one-cycle flush on a mispredicted or excepting head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_ENTRIES = reorder_buffer_pkg::ROB_ENTRIES,
  parameter int unsigned IDX_W       = $clog2(ROB_ENTRIES),
  parameter int unsigned DATA_W      = reorder_buffer_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              disp_valid,
  output logic              disp_ready,
  output logic [IDX_W-1:0]  disp_rob_idx,
  input  logic [4:0]        disp_dest_reg,
  input  logic              disp_reg_write,
  input  logic [DATA_W-1:0] disp_pc,
  input  logic              ex_valid,
  input  logic [IDX_W-1:0]  rob_entry_idx,
  input  logic              br_mispred,
  input  logic              exception,
  input  logic [DATA_W-1:0] ex_val,
  output logic              cmt_valid,
  output logic [4:0]        cmt_dest_reg,
  output logic              cmt_reg_write,
  output logic [DATA_W-1:0] cmt_data,
  output logic              flush,
  output logic [1:0]        flush_cause,
  output logic [DATA_W-1:0] flush_pc
);

  rob_entry_t       entries_q [ROB_ENTRIES];
  rob_entry_t       head_entry;
  logic [IDX_W-1:0] head, tail;
  logic             full, empty;
  logic             alloc, head_ready;
  flush_cause_t     cause;

  rob_ptr_ctrl #(
    .Entries (ROB_ENTRIES),
    .IdxW    (IDX_W)
  ) u_ptr_ctrl (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .alloc_i  (alloc),
    .commit_i (cmt_valid),
    .flush_i  (flush),
    .head_o   (head),
    .tail_o   (tail),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign disp_ready   = !full;
  assign disp_rob_idx = tail;
  assign alloc        = disp_valid && disp_ready;
  assign head_entry   = entries_q[head];
  assign head_ready   = head_entry.valid && head_entry.done && !empty;

  always_comb begin
    cause = FlushNone;
    if (head_ready) begin
      if (head_entry.exc)          cause = FlushException;
      else if (head_entry.mispred) cause = FlushMispred;
    end
  end

  // A mispredicted branch still retires (its link write is architectural); an exception does not.
  always_comb begin
    cmt_valid     = head_ready && !head_entry.exc;
    cmt_dest_reg  = cmt_valid ? head_entry.dest_reg : '0;
    cmt_reg_write = cmt_valid && head_entry.reg_write;
    cmt_data      = cmt_valid ? head_entry.data : '0;
    flush         = (cause != FlushNone);
    flush_cause   = cause;
    flush_pc      = flush ? head_entry.pc : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ROB_ENTRIES); i++) entries_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(ROB_ENTRIES); i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].done  <= 1'b0;
      end
    end else begin
      if (alloc) begin
        entries_q[tail] <= '{valid:     1'b1,
                             done:      1'b0,
                             mispred:   1'b0,
                             exc:       1'b0,
                             dest_reg:  disp_dest_reg,
                             reg_write: disp_reg_write,
                             pc:        disp_pc,
                             data:      '0};
      end
      if (ex_valid && entries_q[rob_entry_idx].valid) begin
        entries_q[rob_entry_idx].done    <= 1'b1;
        entries_q[rob_entry_idx].mispred <= br_mispred;
        entries_q[rob_entry_idx].exc     <= exception;
        entries_q[rob_entry_idx].data    <= ex_val;
      end
      if (cmt_valid) entries_q[head].valid <= 1'b0;
    end
  end

endmodule
